// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, widths and the M/WB stage bundle
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] r2_data;
        logic              zero;
        logic [4:0]        w_reg;
        logic              wr_file;
    } stage_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - ALU-side input bundle and register-file write-back bundle
interface mem_wb_stage_if;
    import mips_pkg::*;

    logic              stall;
    logic              valid_in;
    logic [5:0]        opcode;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] r2_data;
    logic              zero;
    logic [4:0]        w_reg;
    logic              wr_file;

    logic              valid_out;
    logic              wb_en;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_zero;
    logic              misalign;
    logic [DATA_W-1:0] bad_addr;

    modport master (
        output stall, valid_in, opcode, result, r2_data, zero, w_reg, wr_file,
        input  valid_out, wb_en, wb_reg, wb_data, wb_zero, misalign, bad_addr
    );

    modport slave (
        input  stall, valid_in, opcode, result, r2_data, zero, w_reg, wr_file,
        output valid_out, wb_en, wb_reg, wb_data, wb_zero, misalign, bad_addr
    );

endinterface

// File: rtl/dmem_sync.sv
// rtl/dmem_sync.sv - single-port synchronous RAM, registered read-before-write
module dmem_sync #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - two-stage M/WB pipeline: word load/store, write-back bundle, misalign fault
module mem_wb_stage #(
    parameter int         ADDR_W = 8,
    parameter logic [5:0] OP_LW  = 6'b100011,
    parameter logic [5:0] OP_SW  = 6'b101011
) (
    input logic           clk,
    input logic           reset,
    mem_wb_stage_if.slave bus
);
    import mips_pkg::stage_t;
    import mips_pkg::DATA_W;

    stage_t            in_b;
    stage_t            m_q;

    logic              m_mem_op;
    logic              m_misal;
    logic              m_store;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              valid_q;
    logic              wb_en_q;
    logic [4:0]        wb_reg_q;
    logic [DATA_W-1:0] wb_result_q;
    logic              wb_load_q;
    logic              wb_zero_q;
    logic              misalign_q;
    logic [DATA_W-1:0] bad_addr_q;

    always_comb begin
        in_b         = '0;
        in_b.valid   = bus.valid_in;
        in_b.opcode  = bus.opcode;
        in_b.result  = bus.result;
        in_b.r2_data = bus.r2_data;
        in_b.zero    = bus.zero;
        in_b.w_reg   = bus.w_reg;
        in_b.wr_file = bus.wr_file;
    end

    assign m_mem_op = (m_q.opcode == OP_LW) || (m_q.opcode == OP_SW);
    assign m_misal  = m_mem_op && (m_q.result[1:0] != 2'b00);
    assign m_store  = m_q.valid && (m_q.opcode == OP_SW) && !m_misal;

    // Reset and stall both gate the RAM so no write can slip through on those edges.
    assign mem_en = !reset && !bus.stall;
    assign mem_we = mem_en && m_store;

    dmem_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (m_q.result[ADDR_W+1:2]),
        .wdata (m_q.r2_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q         <= '0;
            valid_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= '0;
            wb_result_q <= '0;
            wb_load_q   <= 1'b0;
            wb_zero_q   <= 1'b0;
            misalign_q  <= 1'b0;
            bad_addr_q  <= '0;
        end else if (!bus.stall) begin
            m_q         <= in_b;
            valid_q     <= m_q.valid;
            wb_en_q     <= m_q.valid && !m_misal && (m_q.opcode != OP_SW)
                           && m_q.wr_file && (m_q.w_reg != 5'd0);
            wb_reg_q    <= m_q.w_reg;
            wb_result_q <= m_q.result;
            wb_load_q   <= m_q.valid && (m_q.opcode == OP_LW) && !m_misal;
            wb_zero_q   <= m_q.valid && m_q.zero;
            misalign_q  <= m_q.valid && m_misal;
            if (m_q.valid && m_misal) begin
                bad_addr_q <= m_q.result;
            end
        end
    end

    // The RAM read register holds under stall, so the load mux stays stable too.
    assign bus.wb_data   = wb_load_q ? mem_rdata : wb_result_q;
    assign bus.valid_out = valid_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_zero   = wb_zero_q;
    assign bus.misalign  = misalign_q;
    assign bus.bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed vector bench for mem_wb_stage
module tb_mem_wb_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [31:0] res;
        logic [31:0] r2;
        logic        z;
        logic [4:0]  wr;
        logic        wf;
        logic        e_v;
        logic        e_en;
        logic        e_chk;
        logic [31:0] e_data;
        logic        e_mis;
        logic        e_z;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [5:0] op, logic [31:0] res, logic [31:0] r2,
                                logic z, logic [4:0] wr, logic wf, logic e_v, logic e_en,
                                logic e_chk, logic [31:0] e_data, logic e_mis, logic e_z);
        vec_t t;
        t.v = v; t.op = op; t.res = res; t.r2 = r2; t.z = z; t.wr = wr; t.wf = wf;
        t.e_v = e_v; t.e_en = e_en; t.e_chk = e_chk; t.e_data = e_data;
        t.e_mis = e_mis; t.e_z = e_z;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] res,
                         input logic [31:0] r2, input logic z, input logic [4:0] wr,
                         input logic wf);
        bus.valid_in = v;
        bus.opcode   = op;
        bus.result   = res;
        bus.r2_data  = r2;
        bus.zero     = z;
        bus.w_reg    = wr;
        bus.wr_file  = wf;
    endtask

    task automatic check_wb(input string tag, input logic e_v, input logic e_en,
                            input logic [4:0] e_reg, input logic [31:0] e_data,
                            input logic chk_rd);
        chk({tag, ".valid_out"}, {31'd0, bus.valid_out}, {31'd0, e_v});
        chk({tag, ".wb_en"}, {31'd0, bus.wb_en}, {31'd0, e_en});
        if (chk_rd) begin
            chk({tag, ".wb_reg"}, {27'd0, bus.wb_reg}, {27'd0, e_reg});
            chk({tag, ".wb_data"}, bus.wb_data, e_data);
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        reset = 1'b1;
        drive(1'b1, OP_RTYPE, 32'd15, 32'd0, 1'b0, 5'd5, 1'b1);

        vecs.push_back(mk(1, OP_RTYPE, 32'd15,        32'd0,         0, 5'd5,  1, 1, 1, 1, 32'd15,        0, 0));
        vecs.push_back(mk(1, OP_SW,    32'h10,        32'hDEADBEEF,  0, 5'd0,  0, 1, 0, 0, 32'd0,         0, 0));
        vecs.push_back(mk(1, OP_LW,    32'h10,        32'd0,         0, 5'd9,  1, 1, 1, 1, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(1, OP_LW,    32'h12,        32'd0,         0, 5'd9,  1, 1, 0, 0, 32'd0,         1, 0));
        vecs.push_back(mk(1, OP_LW,    32'h10,        32'd0,         0, 5'd10, 1, 1, 1, 1, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(1, OP_RTYPE, 32'd7,         32'd0,         0, 5'd0,  1, 1, 0, 0, 32'd0,         0, 0));
        vecs.push_back(mk(1, OP_SW,    32'h400,       32'h12345678,  0, 5'd0,  0, 1, 0, 0, 32'd0,         0, 0));
        vecs.push_back(mk(1, OP_LW,    32'h0,         32'd0,         0, 5'd3,  1, 1, 1, 1, 32'h12345678,  0, 0));
        vecs.push_back(mk(0, OP_RTYPE, 32'd99,        32'd0,         1, 5'd4,  1, 0, 0, 0, 32'd0,         0, 0));
        vecs.push_back(mk(1, OP_RTYPE, 32'd0,         32'd0,         1, 5'd4,  1, 1, 1, 1, 32'd0,         0, 1));
        vecs.push_back(mk(1, OP_SW,    32'h13,        32'h00000BAD,  0, 5'd0,  0, 1, 0, 0, 32'd0,         1, 0));
        vecs.push_back(mk(1, OP_LW,    32'h10,        32'd0,         0, 5'd1,  1, 1, 1, 1, 32'hDEADBEEF,  0, 0));
        vecs.push_back(mk(1, OP_SW,    32'h30,        32'h00000077,  0, 5'd0,  0, 1, 0, 0, 32'd0,         0, 0));

        // reset held two edges with valid_in high
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst.valid_out", {31'd0, bus.valid_out}, 32'd0);
            chk("rst.wb_en", {31'd0, bus.wb_en}, 32'd0);
            chk("rst.misalign", {31'd0, bus.misalign}, 32'd0);
        end
        chk("rst.wb_reg", {27'd0, bus.wb_reg}, 32'd0);
        chk("rst.wb_data", bus.wb_data, 32'd0);
        chk("rst.bad_addr", bus.bad_addr, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size() + 2; i++) begin
            if (i == 1) begin
                chk("first_edge.valid_out", {31'd0, bus.valid_out}, 32'd0);
            end
            if (i >= 2) begin
                vec_t e;
                string tag;
                e = vecs[i-2];
                tag = $sformatf("vec%0d", i - 2);
                check_wb(tag, e.e_v, e.e_en, e.wr, e.e_data, e.e_chk);
                chk({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, e.e_mis});
                chk({tag, ".wb_zero"}, {31'd0, bus.wb_zero}, {31'd0, e.e_z});
                if (e.e_mis) begin
                    chk({tag, ".bad_addr"}, bus.bad_addr, e.res);
                end
            end
            if (i < vecs.size()) begin
                drive(vecs[i].v, vecs[i].op, vecs[i].res, vecs[i].r2, vecs[i].z, vecs[i].wr, vecs[i].wf);
            end else begin
                drive(1'b0, OP_RTYPE, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("bad_addr_hold", bus.bad_addr, 32'h13);

        // stall for three cycles with an sw sitting in M
        drive(1'b1, OP_RTYPE, 32'h55, 32'd0, 1'b0, 5'd6, 1'b1);
        @(posedge clk); @(negedge clk);
        drive(1'b1, OP_SW, 32'h20, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
        @(posedge clk); @(negedge clk);
        check_wb("pre_stall", 1'b1, 1'b1, 5'd6, 32'h55, 1'b1);
        bus.stall = 1'b1;
        drive(1'b1, OP_LW, 32'h44, 32'd0, 1'b0, 5'd11, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            check_wb($sformatf("stall%0d", c), 1'b1, 1'b1, 5'd6, 32'h55, 1'b1);
        end
        bus.stall = 1'b0;
        drive(1'b1, OP_LW, 32'h20, 32'd0, 1'b0, 5'd7, 1'b1);
        @(posedge clk); @(negedge clk);
        check_wb("post_stall_sw", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        drive(1'b0, OP_RTYPE, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk); @(negedge clk);
        check_wb("post_stall_lw", 1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1);

        // reset with an sw in M must not write
        drive(1'b1, OP_SW, 32'h30, 32'h000000BB, 1'b0, 5'd0, 1'b0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        drive(1'b0, OP_RTYPE, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk); @(negedge clk);
        check_wb("mid_reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        reset = 1'b0;
        drive(1'b1, OP_LW, 32'h30, 32'd0, 1'b0, 5'd8, 1'b1);
        @(posedge clk); @(negedge clk);
        drive(1'b0, OP_RTYPE, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk); @(negedge clk);
        check_wb("after_reset_lw", 1'b1, 1'b1, 5'd8, 32'h00000077, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
